tex_perf_collector: RTL and testbench



---
 rtl/tex_pkg.sv | 15 +
 rtl/tex_lane_popcount.sv | 17 +
 rtl/tex_perf_collector.sv | 103 ++++++++++
 tb/tb_tex_perf_collector.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tex_pkg.sv
// Shared texture-unit definitions: lane count, perf counter layout and
// outstanding-read tracker width used by the texture perf interface.
package tex_pkg;

    localparam int TEX_NUM_LANES     = 4;
    localparam int TEX_PERF_CTR_BITS = 44;
    localparam int TEX_PENDING_BITS  = 8;

    typedef struct packed {
        logic [TEX_PERF_CTR_BITS-1:0] mem_reads;
        logic [TEX_PERF_CTR_BITS-1:0] mem_latency;
        logic [TEX_PERF_CTR_BITS-1:0] stall_cycles;
    } tex_perf_t;

endpackage

// File: rtl/tex_lane_popcount.sv
// Counts the active lanes of a texture memory lane mask.
module tex_lane_popcount #(
    parameter int NUM_LANES = 4,
    localparam int CNT_W    = $clog2(NUM_LANES + 1)
) (
    input  logic [NUM_LANES-1:0] mask,
    output logic [CNT_W-1:0]     count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            count = count + CNT_W'(mask[i]);
        end
    end

endmodule

// File: rtl/tex_perf_collector.sv
// Texture-unit perf counter producer: lane reads issued, accumulated per-lane
// read latency and request stall cycles, plus the outstanding-read tracker.
module tex_perf_collector
    import tex_pkg::*;
#(
    parameter int NUM_LANES     = TEX_NUM_LANES,
    parameter int PERF_CTR_BITS = TEX_PERF_CTR_BITS,
    parameter int PENDING_BITS  = TEX_PENDING_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     perf_enable,
    input  logic                     tex_req_valid,
    input  logic                     tex_req_ready,
    input  logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    input  logic [NUM_LANES-1:0]     mem_req_mask,
    input  logic                     mem_rsp_valid,
    input  logic                     mem_rsp_ready,
    input  logic [NUM_LANES-1:0]     mem_rsp_mask,
    output logic [PERF_CTR_BITS-1:0] mem_reads,
    output logic [PERF_CTR_BITS-1:0] mem_latency,
    output logic [PERF_CTR_BITS-1:0] stall_cycles,
    output logic [PENDING_BITS-1:0]  pending_reads
);

    localparam int CNT_W    = $clog2(NUM_LANES + 1);
    localparam int SUM_W    = ((PENDING_BITS > CNT_W) ? PENDING_BITS : CNT_W) + 2;
    localparam int PEND_MAX = (1 << PENDING_BITS) - 1;

    logic                     req_fire;
    logic                     rsp_fire;
    logic [NUM_LANES-1:0]     req_lanes;
    logic [NUM_LANES-1:0]     rsp_lanes;
    logic [CNT_W-1:0]         req_cnt;
    logic [CNT_W-1:0]         rsp_cnt;
    logic signed [SUM_W-1:0]  pending_sum;

    logic [PENDING_BITS-1:0]  pending_p1;
    logic [PERF_CTR_BITS-1:0] reads_p1;
    logic [PERF_CTR_BITS-1:0] latency_p1;
    logic [PERF_CTR_BITS-1:0] stall_p1;

    function automatic logic [PENDING_BITS-1:0] clamp_pending(
        input logic signed [SUM_W-1:0] v
    );
        if (v < 0) return '0;
        if (v > $signed(SUM_W'(PEND_MAX))) return '1;
        return v[PENDING_BITS-1:0];
    endfunction

    assign req_fire  = mem_req_valid & mem_req_ready;
    assign rsp_fire  = mem_rsp_valid & mem_rsp_ready;
    assign req_lanes = req_fire ? mem_req_mask : '0;
    assign rsp_lanes = rsp_fire ? mem_rsp_mask : '0;

    tex_lane_popcount #(.NUM_LANES(NUM_LANES)) u_req_popcount (
        .mask  (req_lanes),
        .count (req_cnt)
    );

    tex_lane_popcount #(.NUM_LANES(NUM_LANES)) u_rsp_popcount (
        .mask  (rsp_lanes),
        .count (rsp_cnt)
    );

    assign pending_sum = SUM_W'(pending_p1) + SUM_W'(req_cnt) - SUM_W'(rsp_cnt);

    // Stage p1: tracker always follows traffic; counters only advance when enabled.
    // Latency uses the pre-update pending count so a lane counts from issue+1 to its response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_p1 <= '0;
            reads_p1   <= '0;
            latency_p1 <= '0;
            stall_p1   <= '0;
        end else begin
            pending_p1 <= clamp_pending(pending_sum);
            if (perf_enable) begin
                reads_p1   <= reads_p1 + PERF_CTR_BITS'(req_cnt);
                latency_p1 <= latency_p1 + PERF_CTR_BITS'(pending_p1);
                if (tex_req_valid && !tex_req_ready) begin
                    stall_p1 <= stall_p1 + PERF_CTR_BITS'(1);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            assert (pending_sum >= 0)
                else $warning("tex_perf_collector: response for more lanes than outstanding");
            assert (pending_sum <= $signed(SUM_W'(PEND_MAX)))
                else $warning("tex_perf_collector: outstanding read count exceeds tracker range");
        end
    end

    assign mem_reads     = reads_p1;
    assign mem_latency   = latency_p1;
    assign stall_cycles  = stall_p1;
    assign pending_reads = pending_p1;

endmodule

// File: tb/tb_tex_perf_collector.sv
// Self-checking bench for tex_perf_collector: directed scenarios plus random
// traffic compared against a cycle-level counting model.
module tb_tex_perf_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        perf_enable;
    logic        tex_req_valid, tex_req_ready;
    logic        mem_req_valid, mem_req_ready;
    logic [3:0]  mem_req_mask;
    logic        mem_rsp_valid, mem_rsp_ready;
    logic [3:0]  mem_rsp_mask;
    logic [43:0] mem_reads, mem_latency, stall_cycles;
    logic [7:0]  pending_reads;
    logic [7:0]  s_reads, s_latency, s_stall, s_pending;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: lane-level bookkeeping kept in wide integers.
    logic [63:0] m_reads, m_lat, m_stall;
    int          m_pend;

    tex_perf_collector u_dut (
        .clk(clk), .reset(reset), .perf_enable(perf_enable),
        .tex_req_valid(tex_req_valid), .tex_req_ready(tex_req_ready),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_mask(mem_req_mask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_mask(mem_rsp_mask),
        .mem_reads(mem_reads), .mem_latency(mem_latency), .stall_cycles(stall_cycles),
        .pending_reads(pending_reads)
    );

    tex_perf_collector #(.PERF_CTR_BITS(8)) u_dut8 (
        .clk(clk), .reset(reset), .perf_enable(perf_enable),
        .tex_req_valid(tex_req_valid), .tex_req_ready(tex_req_ready),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_mask(mem_req_mask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_mask(mem_rsp_mask),
        .mem_reads(s_reads), .mem_latency(s_latency), .stall_cycles(s_stall),
        .pending_reads(s_pending)
    );

    task automatic idle();
        perf_enable   = 1'b1;
        tex_req_valid = 1'b0; tex_req_ready = 1'b0;
        mem_req_valid = 1'b0; mem_req_ready = 1'b0; mem_req_mask = 4'b0000;
        mem_rsp_valid = 1'b0; mem_rsp_ready = 1'b0; mem_rsp_mask = 4'b0000;
    endtask

    task automatic issue(input logic [3:0] m);
        mem_req_valid = 1'b1; mem_req_ready = 1'b1; mem_req_mask = m;
    endtask

    task automatic respond(input logic [3:0] m);
        mem_rsp_valid = 1'b1; mem_rsp_ready = 1'b1; mem_rsp_mask = m;
    endtask

    // Advance one clock; the model applies the rules to the inputs seen at the edge.
    task automatic step();
        int rq, rs, np;
        @(posedge clk);
        if (!reset) begin
            m_reads = '0; m_lat = '0; m_stall = '0; m_pend = 0;
        end else begin
            rq = (mem_req_valid && mem_req_ready) ? $countones(mem_req_mask) : 0;
            rs = (mem_rsp_valid && mem_rsp_ready) ? $countones(mem_rsp_mask) : 0;
            if (perf_enable) begin
                m_reads = m_reads + 64'(rq);
                m_lat   = m_lat + 64'(m_pend);
                if (tex_req_valid && !tex_req_ready) m_stall = m_stall + 64'd1;
            end
            np = m_pend + rq - rs;
            if (np < 0) np = 0;
            if (np > 255) np = 255;
            m_pend = np;
        end
        #1;
    endtask

    task automatic restart();
        idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic drive_random(input bit legal);
        int rq;
        perf_enable   = ($urandom_range(0, 9) != 0);
        tex_req_valid = 1'($urandom);
        tex_req_ready = 1'($urandom);
        mem_req_valid = 1'($urandom);
        mem_req_ready = 1'($urandom);
        mem_req_mask  = 4'($urandom);
        mem_rsp_valid = ($urandom_range(0, 9) < 7);
        mem_rsp_ready = ($urandom_range(0, 9) < 8);
        mem_rsp_mask  = 4'($urandom);
        if (legal) begin
            rq = (mem_req_valid && mem_req_ready) ? $countones(mem_req_mask) : 0;
            if (m_pend + rq > 240) begin
                mem_req_valid = 1'b0;
                rq = 0;
            end
            if ($countones(mem_rsp_mask) > m_pend + rq) mem_rsp_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_random(1'b0);
            step();
            vectors++;
            if ({mem_reads, mem_latency, stall_cycles, pending_reads, s_reads, s_latency, s_stall, s_pending} !== '0) begin
                miscompares++;
                $display("FAIL reset_hold cycle %0d: reads=%h lat=%h stall=%h pend=%h small=%h/%h/%h/%h, required all 0",
                         i, mem_reads, mem_latency, stall_cycles, pending_reads, s_reads, s_latency, s_stall, s_pending);
            end
        end
        idle();
        step();
        reset = 1'b1;
        issue(4'b1111);
        step();
        idle();
        vectors++;
        if (mem_reads !== 44'd4 || pending_reads !== 8'd4) begin
            miscompares++;
            $display("FAIL reset_first_req: reads=%0d pend=%0d, required reads=4 pend=4", mem_reads, pending_reads);
        end
        respond(4'b1111);
        step();
        idle();
        vectors++;
        if (pending_reads !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_drain: pend=%0d, required 0", pending_reads);
        end
    endtask

    task automatic test_fixed_latency();
        restart();
        issue(4'b0011);
        step();
        idle();
        for (int i = 0; i < 4; i++) step();
        respond(4'b0011);
        step();
        idle();
        vectors++;
        if (mem_reads !== 44'd2 || mem_latency !== 44'd10 || pending_reads !== 8'd0) begin
            miscompares++;
            $display("FAIL fixed_latency: reads=%0d lat=%0d pend=%0d, required reads=2 lat=10 pend=0",
                     mem_reads, mem_latency, pending_reads);
        end
    endtask

    task automatic test_simultaneous();
        restart();
        issue(4'b0111);
        step();
        idle();
        vectors++;
        if (pending_reads !== 8'd3 || mem_latency !== 44'd0) begin
            miscompares++;
            $display("FAIL simul_setup: pend=%0d lat=%0d, required pend=3 lat=0", pending_reads, mem_latency);
        end
        issue(4'b0101);
        respond(4'b0001);
        step();
        idle();
        vectors++;
        if (pending_reads !== 8'd4 || mem_latency !== 44'd3 || mem_reads !== 44'd5) begin
            miscompares++;
            $display("FAIL simul_update: pend=%0d lat=%0d reads=%0d, required pend=4 lat=3 reads=5",
                     pending_reads, mem_latency, mem_reads);
        end
        respond(4'b1111);
        step();
        idle();
    endtask

    task automatic test_stall();
        restart();
        tex_req_valid = 1'b1;
        tex_req_ready = 1'b0;
        for (int i = 0; i < 7; i++) step();
        tex_req_ready = 1'b1;
        step();
        tex_req_valid = 1'b0;
        tex_req_ready = 1'b0;
        step();
        vectors++;
        if (stall_cycles !== 44'd7) begin
            miscompares++;
            $display("FAIL stall_count: stall=%0d, required 7", stall_cycles);
        end
    endtask

    task automatic test_enable_gating();
        restart();
        issue(4'b1111);
        step();
        idle();
        perf_enable = 1'b0;
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if (pending_reads !== 8'd4 || mem_latency !== 44'd0) begin
            miscompares++;
            $display("FAIL enable_frozen: pend=%0d lat=%0d, required pend=4 lat=0", pending_reads, mem_latency);
        end
        perf_enable = 1'b1;
        step();
        respond(4'b1111);
        step();
        idle();
        vectors++;
        if (mem_latency !== 44'd8 || pending_reads !== 8'd0 || mem_reads !== 44'd4) begin
            miscompares++;
            $display("FAIL enable_resume: lat=%0d pend=%0d reads=%0d, required lat=8 pend=0 reads=4",
                     mem_latency, pending_reads, mem_reads);
        end
    endtask

    task automatic test_wrap();
        restart();
        issue(4'b0001);
        step();
        respond(4'b0001);
        for (int i = 0; i < 254; i++) step();
        vectors++;
        if (s_reads !== 8'd255 || s_pending !== 8'd1) begin
            miscompares++;
            $display("FAIL wrap_preload: small reads=%0d pend=%0d, required reads=255 pend=1", s_reads, s_pending);
        end
        step();
        vectors++;
        if (s_reads !== 8'd0 || mem_reads !== 44'd256) begin
            miscompares++;
            $display("FAIL wrap_rollover: small reads=%0d wide reads=%0d, required 0 and 256", s_reads, mem_reads);
        end
        idle();
        respond(4'b0001);
        step();
        idle();
    endtask

    task automatic test_underflow();
        restart();
        respond(4'b1111);
        step();
        idle();
        vectors++;
        if (pending_reads !== 8'd0 || s_pending !== 8'd0) begin
            miscompares++;
            $display("FAIL underflow_clamp: pend=%0d small pend=%0d, required 0", pending_reads, s_pending);
        end
    endtask

    task automatic test_random();
        restart();
        for (int i = 0; i < 400; i++) begin
            drive_random(1'b1);
            step();
            vectors++;
            if ({mem_reads, mem_latency, stall_cycles, pending_reads} !==
                {m_reads[43:0], m_lat[43:0], m_stall[43:0], 8'(m_pend)}) begin
                miscompares++;
                $display("FAIL random cycle %0d: reads=%0d lat=%0d stall=%0d pend=%0d, required %0d %0d %0d %0d",
                         i, mem_reads, mem_latency, stall_cycles, pending_reads,
                         m_reads[43:0], m_lat[43:0], m_stall[43:0], m_pend);
            end
            vectors++;
            if ({s_reads, s_latency, s_stall} !== {m_reads[7:0], m_lat[7:0], m_stall[7:0]}) begin
                miscompares++;
                $display("FAIL random_small cycle %0d: reads=%0d lat=%0d stall=%0d, required %0d %0d %0d",
                         i, s_reads, s_latency, s_stall, m_reads[7:0], m_lat[7:0], m_stall[7:0]);
            end
        end
        idle();
    endtask

    initial begin
        m_reads = '0; m_lat = '0; m_stall = '0; m_pend = 0;
        idle();
        reset = 1'b0;
        test_reset();
        test_fixed_latency();
        test_simultaneous();
        test_stall();
        test_enable_gating();
        test_wrap();
        test_underflow();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
